// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the ALU operation sequencer.
//   - opcode encodings accepted on the request interface
//   - one-hot select encodings, bit order identical to the MuxOut sel port
//   - sequencer FSM state type
//   - sel_for_op(): opcode -> one-hot select (all-zero for reserved)
package alu_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NOT  = 3'd3;
  localparam logic [2:0] OP_ADD  = 3'd4;
  localparam logic [2:0] OP_SUB  = 3'd5;
  localparam logic [2:0] OP_MUL  = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  localparam logic [5:0] SEL_NONE = 6'b000000;
  localparam logic [5:0] SEL_AND  = 6'b000001;
  localparam logic [5:0] SEL_OR   = 6'b000010;
  localparam logic [5:0] SEL_XOR  = 6'b000100;
  localparam logic [5:0] SEL_NOT  = 6'b001000;
  localparam logic [5:0] SEL_ADD  = 6'b010000;  // shared by ADD and SUB
  localparam logic [5:0] SEL_MUL  = 6'b100000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  function automatic logic [5:0] sel_for_op(input logic [2:0] op);
    logic [5:0] s;
    s = SEL_NONE;
    case (op)
      OP_AND:  s = SEL_AND;
      OP_OR:   s = SEL_OR;
      OP_XOR:  s = SEL_XOR;
      OP_NOT:  s = SEL_NOT;
      OP_ADD:  s = SEL_ADD;
      OP_SUB:  s = SEL_ADD;
      OP_MUL:  s = SEL_MUL;
      default: s = SEL_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/shift_add_mult.sv
// shift_add_mult: iterative unsigned k x k multiplier, one partial product
// per cycle.
//   clk, rst : clock, asynchronous active-high reset
//   start    : load operands, clear accumulator, begin k iterations
//   a, b     : multiplicand / multiplier (sampled on start)
//   busy     : iterations in progress
//   done     : high during the final iteration cycle
//   prod     : accumulator value after the current iteration; equals the
//              full 2k-bit product while done is high
module shift_add_mult
  import alu_pkg::*;
#(
  parameter int k = 7
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [k-1:0]   a,
  input  logic [k-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*k-1:0] prod
);

  localparam int CW = $clog2(k + 1);

  logic [2*k-1:0] acc_q,    acc_d;
  logic [2*k-1:0] mcand_q,  mcand_d;
  logic [k-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]  cnt_q,    cnt_d;
  logic           busy_q,   busy_d;
  logic [2*k-1:0] step_sum;

  assign step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  // done/prod look one step ahead so the caller can capture the product on
  // the same edge that performs the last iteration.
  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CW'(1));
  assign prod = step_sum;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      acc_d    = '0;
      mcand_d  = {{k{1'b0}}, a};
      mplier_d = b;
      cnt_d    = CW'(k);
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = step_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/alu_op_seq.sv
// alu_op_seq: request sequencer in front of the ALU output mux.
// Accepts one operation over op_valid/op_ready, registers the operands,
// drives the one-hot mux select and add/sub control, computes MUL locally
// with shift_add_mult, and holds the result until res_ready.
//   clk, rst           : clock, asynchronous active-high reset
//   op_valid/op_ready  : request handshake (op_ready high only in IDLE)
//   opcode, a, b       : operation and k-bit operands
//   opA, opB           : registered operands for the logic/addSub units
//   sub                : subtract control for the addSub unit
//   sel                : one-hot MuxOut select (all-zero when idle/illegal)
//   mult, mult_ovf     : low k bits of A*B, and upper-half-nonzero flag
//   illegal            : accepted opcode was the reserved one
//   res_valid/res_ready: result handshake
//
// state | meaning
// IDLE  | waiting for a request, op_ready=1, sel=0
// MUL   | shift-add multiply in progress, outputs other than mult stable
// HOLD  | result presented, all outputs frozen until res_ready
module alu_op_seq
  import alu_pkg::*;
#(
  parameter int k = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [2:0]   opcode,
  input  logic [k-1:0] a,
  input  logic [k-1:0] b,
  output logic [k-1:0] opA,
  output logic [k-1:0] opB,
  output logic         sub,
  output logic [5:0]   sel,
  output logic [k-1:0] mult,
  output logic         mult_ovf,
  output logic         illegal,
  output logic         res_valid,
  input  logic         res_ready
);

  state_t         state_q, state_d;
  logic [k-1:0]   opa_q,   opa_d;
  logic [k-1:0]   opb_q,   opb_d;
  logic           sub_q,   sub_d;
  logic [5:0]     sel_q,   sel_d;
  logic [k-1:0]   mult_q,  mult_d;
  logic           ovf_q,   ovf_d;
  logic           ill_q,   ill_d;

  logic           mul_start;
  logic           mul_busy;
  logic           mul_done;
  logic [2*k-1:0] mul_prod;

  // Operands go straight from the request bus so the first iteration
  // starts on the cycle after accept.
  shift_add_mult #(.k(k)) u_mult (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (a),
    .b     (b),
    .busy  (mul_busy),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  always_comb begin
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    sub_d     = sub_q;
    sel_d     = sel_q;
    mult_d    = mult_q;
    ovf_d     = ovf_q;
    ill_d     = ill_q;
    mul_start = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          opa_d  = a;
          opb_d  = b;
          mult_d = '0;
          ovf_d  = 1'b0;
          ill_d  = 1'b0;
          sub_d  = (opcode == OP_SUB);
          sel_d  = sel_for_op(opcode);
          if (opcode == OP_MUL) begin
            mul_start = 1'b1;
            state_d   = ST_MUL;
          end else begin
            ill_d   = (opcode == OP_RSVD);
            state_d = ST_HOLD;
          end
        end
      end

      ST_MUL: begin
        if (mul_done) begin
          mult_d  = mul_prod[k-1:0];
          ovf_d   = |mul_prod[2*k-1:k];
          state_d = ST_HOLD;
        end else if (!mul_busy) begin
          // Engine idle without completing: never expected, recover to IDLE.
          sel_d   = SEL_NONE;
          state_d = ST_IDLE;
        end
      end

      ST_HOLD: begin
        if (res_ready) begin
          sel_d   = SEL_NONE;
          state_d = ST_IDLE;
        end
      end

      default: begin
        sel_d   = SEL_NONE;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sub_q   <= 1'b0;
      sel_q   <= SEL_NONE;
      mult_q  <= '0;
      ovf_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sub_q   <= sub_d;
      sel_q   <= sel_d;
      mult_q  <= mult_d;
      ovf_q   <= ovf_d;
      ill_q   <= ill_d;
    end
  end

  assign op_ready  = (state_q == ST_IDLE);
  assign res_valid = (state_q == ST_HOLD);
  assign opA       = opa_q;
  assign opB       = opb_q;
  assign sub       = sub_q;
  assign sel       = sel_q;
  assign mult      = mult_q;
  assign mult_ovf  = ovf_q;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_op_seq.sv
module tb_alu_op_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       op_valid;
  logic       op_ready;
  logic [2:0] opcode;
  logic [6:0] a, b;
  logic [6:0] opA, opB;
  logic       sub;
  logic [5:0] sel;
  logic [6:0] mult;
  logic       mult_ovf;
  logic       illegal;
  logic       res_valid;
  logic       res_ready;

  always #5 clk = ~clk;

  alu_op_seq #(.k(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .opA       (opA),
    .opB       (opB),
    .sub       (sub),
    .sel       (sel),
    .mult      (mult),
    .mult_ovf  (mult_ovf),
    .illegal   (illegal),
    .res_valid (res_valid),
    .res_ready (res_ready)
  );

  typedef struct {
    logic [2:0] op;
    logic [6:0] a;
    logic [6:0] b;
    int         hold;
    bit         pulse;
    logic [5:0] sel;
    logic       sub;
    logic [6:0] mult;
    logic       ovf;
    logic       ill;
    int         lat;
  } vec_t;

  typedef struct {
    logic [5:0] sel;
    logic       sub;
    logic [6:0] opa;
    logic [6:0] opb;
    logic [6:0] mult;
    logic       ovf;
    logic       ill;
  } exp_t;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  vec_t vecs[11];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [6:0] va, input logic [6:0] vb,
                              input int hold, input bit pulse, input logic [5:0] esel);
    vec_t v;
    logic [13:0] p;
    p       = 14'(va) * 14'(vb);
    v.op    = op;
    v.a     = va;
    v.b     = vb;
    v.hold  = hold;
    v.pulse = pulse;
    v.sel   = esel;
    v.sub   = (op == 3'd5);
    v.mult  = (op == 3'd6) ? p[6:0] : 7'd0;
    v.ovf   = (op == 3'd6) ? (p[13:7] != 7'd0) : 1'b0;
    v.ill   = (op == 3'd7);
    v.lat   = (op == 3'd6) ? 8 : 1;
    return v;
  endfunction

  always @(negedge clk) chk("sel_onehot0", 16'($onehot0(sel)), 16'd1);

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e, got;
    int   lat;
    bit   seen;
    logic [5:0] s0; logic [6:0] a0, b0, m0; logic sub0, ovf0, ill0;

    @(posedge clk); #1;
    op_valid  = 1'b1;
    opcode    = v.op;
    a         = v.a;
    b         = v.b;
    res_ready = 1'b0;
    e.sel = v.sel; e.sub = v.sub; e.opa = v.a; e.opb = v.b;
    e.mult = v.mult; e.ovf = v.ovf; e.ill = v.ill;
    sb.push_back(e);
    @(posedge clk); #1;
    op_valid = 1'b0;
    a = 7'h00; b = 7'h00;

    lat  = 0;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      lat++;
      if (res_valid) seen = 1;
      else begin
        chk($sformatf("v%0d mul_busy_ready", idx), 16'(op_ready), 16'd0);
        chk($sformatf("v%0d mul_sel", idx), 16'(sel), 16'(v.sel));
        chk($sformatf("v%0d mul_opA", idx), 16'(opA), 16'(v.a));
      end
    end
    chk($sformatf("v%0d res_valid_seen", idx), 16'(seen), 16'd1);
    if (!seen) return;
    chk($sformatf("v%0d latency", idx), 16'(lat), 16'(v.lat));

    if (sb.size() == 0) begin
      chk($sformatf("v%0d sb_nonempty", idx), 16'd0, 16'd1);
      return;
    end
    got = sb.pop_front();
    chk($sformatf("v%0d sel", idx), 16'(sel), 16'(got.sel));
    chk($sformatf("v%0d sub", idx), 16'(sub), 16'(got.sub));
    chk($sformatf("v%0d opA", idx), 16'(opA), 16'(got.opa));
    chk($sformatf("v%0d opB", idx), 16'(opB), 16'(got.opb));
    chk($sformatf("v%0d mult", idx), 16'(mult), 16'(got.mult));
    chk($sformatf("v%0d mult_ovf", idx), 16'(mult_ovf), 16'(got.ovf));
    chk($sformatf("v%0d illegal", idx), 16'(illegal), 16'(got.ill));
    chk($sformatf("v%0d op_ready_hold", idx), 16'(op_ready), 16'd0);

    s0 = sel; a0 = opA; b0 = opB; m0 = mult; sub0 = sub; ovf0 = mult_ovf; ill0 = illegal;
    for (int h = 0; h < v.hold; h++) begin
      if (v.pulse && h == 0) begin
        op_valid = 1'b1; opcode = 3'd0; a = 7'h5A; b = 7'h3C;
      end
      @(negedge clk);
      op_valid = 1'b0;
      chk($sformatf("v%0d hold%0d res_valid", idx, h), 16'(res_valid), 16'd1);
      chk($sformatf("v%0d hold%0d outs", idx, h),
          {sel, opA, sub, ovf0 ^ mult_ovf, ill0 ^ illegal},
          {s0, a0, sub0, 1'b0, 1'b0});
      chk($sformatf("v%0d hold%0d opB_mult", idx, h), {2'b0, opB, mult}, {2'b0, b0, m0});
    end

    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk($sformatf("v%0d idle_ready", idx), 16'(op_ready), 16'd1);
    chk($sformatf("v%0d idle_valid", idx), 16'(res_valid), 16'd0);
    chk($sformatf("v%0d idle_sel", idx), 16'(sel), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = mk(3'd0, 7'h55, 7'h33, 0, 0, 6'b000001);
    vecs[1]  = mk(3'd1, 7'h12, 7'h21, 1, 0, 6'b000010);
    vecs[2]  = mk(3'd2, 7'h7F, 7'h0F, 0, 0, 6'b000100);
    vecs[3]  = mk(3'd3, 7'h2A, 7'h00, 0, 0, 6'b001000);
    vecs[4]  = mk(3'd4, 7'd100, 7'd50, 0, 0, 6'b010000);
    vecs[5]  = mk(3'd5, 7'd20, 7'd7, 0, 0, 6'b010000);
    vecs[6]  = mk(3'd6, 7'd9, 7'd11, 0, 0, 6'b100000);
    vecs[7]  = mk(3'd6, 7'd127, 7'd2, 5, 0, 6'b100000);
    vecs[8]  = mk(3'd6, 7'h7F, 7'h7F, 1, 0, 6'b100000);
    vecs[9]  = mk(3'd6, 7'h00, 7'h55, 0, 0, 6'b100000);
    vecs[10] = mk(3'd7, 7'h11, 7'h22, 3, 1, 6'b000000);

    rst = 1'b1; op_valid = 1'b0; opcode = 3'd0; a = 7'h0; b = 7'h0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset op_ready", 16'(op_ready), 16'd1);
    chk("reset outputs", {opA, opB, sub, illegal}, 16'd0);
    chk("reset sel_valid_mult", {sel, res_valid, mult_ovf, 1'b0, mult}, 16'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Reset during the third MUL cycle, then confirm no stale result.
    @(posedge clk); #1;
    op_valid = 1'b1; opcode = 3'd6; a = 7'd9; b = 7'd11;
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    chk("midmul in_mul", {sel, op_ready, res_valid}, {6'b100000, 1'b0, 1'b0});
    rst = 1'b1;
    #1;
    chk("midmul async sel_valid", {sel, res_valid, mult_ovf, illegal, sub}, 16'd0);
    chk("midmul async ops", {2'b0, opA, opB}, 16'd0);
    chk("midmul async mult_ready", {mult, op_ready}, {7'd0, 1'b1});
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      chk($sformatf("post_reset c%0d", c), {op_ready, res_valid}, 16'b10);
    end

    // Sequencer still works after a mid-multiply reset.
    run_vec(mk(3'd6, 7'd5, 7'd6, 0, 0, 6'b100000), 11);

    chk("scoreboard drained", 16'(sb.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
